// File: rtl/hilo_muldiv.sv
// HI/LO architectural registers plus an iterative radix-2 multiply / restoring-divide engine.
// MULT/DIV results land DATA_W+2 cycles after the start edge; MTHI/MTLO land at the next edge.
module hilo_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*DATA_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]       b_mag_q, b_mag_d;
    logic                    is_div_q, is_div_d;
    logic                    neg_lo_q, neg_lo_d;
    logic                    neg_hi_q, neg_hi_d;
    logic [DATA_W-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic                    busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic                    signed_op, a_neg, b_neg;
    logic [DATA_W-1:0]       a_mag, b_mag;
    logic [DATA_W:0]         mul_sum, div_trial;
    logic [2*DATA_W-1:0]     mul_next, div_next, prod_fix;
    logic [DATA_W-1:0]       quo_fix, rem_fix;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = signed_op & src_a[DATA_W-1];
    assign b_neg     = signed_op & src_b[DATA_W-1];
    assign a_mag     = a_neg ? -src_a : src_a;
    assign b_mag     = b_neg ? -src_b : src_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + ({1'b0, b_mag_q} & {(DATA_W+1){acc_q[0]}});
    assign mul_next  = {mul_sum, acc_q[DATA_W-1:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left each step.
    assign div_trial = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, b_mag_q};
    assign div_next  = div_trial[DATA_W] ? {acc_q[2*DATA_W-2:0], 1'b0}
                                         : {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

    assign prod_fix  = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix   = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem_fix   = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_mag_d  = b_mag_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            acc_d    = {{DATA_W{1'b0}}, a_mag};
                            b_mag_d  = b_mag;
                            is_div_d = (op == OP_DIV) || (op == OP_DIVU);
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = a_neg;
                            cnt_d    = '0;
                            state_d  = S_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (b_mag_q == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_mag_q  <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_mag_q  <= b_mag_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus randomized ops against a plain-arithmetic model.
module tb_hilo_muldiv;
    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic         cpu_clk_50M = 1'b0;
    logic         cpu_rst_n   = 1'b0;
    logic         start       = 1'b0;
    logic [2:0]   op          = 3'b000;
    logic [W-1:0] src_a       = '0;
    logic [W-1:0] src_b       = '0;
    logic         flush       = 1'b0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi_o, lo_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    hilo_muldiv #(.DATA_W(W)) dut (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy), .done(done),
        .div_zero(div_zero), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result of one arithmetic op; returns whether it was a divide by zero.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output bit dz);
        longint      sa, sb, sq, sr;
        logic [63:0] r64;
        dz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT: begin
                r64 = 64'(sa * sb);
                {exp_hi, exp_lo} = r64;
            end
            OP_MULTU: begin
                r64 = {32'b0, a} * {32'b0, b};
                {exp_hi, exp_lo} = r64;
            end
            OP_DIV: begin
                if (b == '0) dz = 1'b1;
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r64 = 64'(sq); exp_lo = r64[31:0];
                    r64 = 64'(sr); exp_hi = r64[31:0];
                end
            end
            default: begin
                if (b == '0) dz = 1'b1;
                else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
        endcase
    endtask

    task automatic issue_mt(input logic [2:0] o, input logic [W-1:0] d);
        @(negedge cpu_clk_50M);
        start = 1'b1; op = o; src_a = d; src_b = $urandom;
        @(negedge cpu_clk_50M);
        start = 1'b0;
        if (o == OP_MTHI) exp_hi = d; else exp_lo = d;
        check("mt_hi", 64'(hi_o), 64'(exp_hi));
        check("mt_lo", 64'(lo_o), 64'(exp_lo));
        check("mt_busy", 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit dz;
        bit early;
        early = 1'b0;
        model(o, a, b, dz);
        @(negedge cpu_clk_50M);
        start = 1'b1; op = o; src_a = a; src_b = b;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge cpu_clk_50M);
            if (k == 1) start = 1'b0;
            if (k == 5) begin start = 1'b1; op = OP_MTHI; src_a = $urandom; end
            if (k == 6) start = 1'b0;
            if (k == 1) check("busy_rise", 64'(busy), 64'd1);
            if (k == W + 1) check("busy_fix", 64'(busy), 64'd1);
            if (k <= W + 1 && (done || !busy || div_zero)) early = 1'b1;
            if (k == W + 2) begin
                check("done", 64'(done), 64'd1);
                check("busy_end", 64'(busy), 64'd0);
                check("div_zero", 64'(div_zero), 64'(dz));
                check("hi", 64'(hi_o), 64'(exp_hi));
                check("lo", 64'(lo_o), 64'(exp_lo));
            end
        end
        check("early_done", 64'(early), 64'd0);
        @(negedge cpu_clk_50M);
        check("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        bit seen;
        logic [2:0]   o;
        logic [W-1:0] a, b;

        repeat (2) @(negedge cpu_clk_50M);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        cpu_rst_n = 1'b1;

        // Back-to-back MTHI then MTLO.
        @(negedge cpu_clk_50M);
        start = 1'b1; op = OP_MTHI; src_a = 32'h12345678;
        @(negedge cpu_clk_50M);
        op = OP_MTLO; src_a = 32'h9ABCDEF0;
        check("mthi", 64'(hi_o), 64'h12345678);
        check("mthi_busy", 64'(busy), 64'd0);
        @(negedge cpu_clk_50M);
        start = 1'b0;
        check("mtlo", 64'(lo_o), 64'h9ABCDEF0);
        check("mtlo_busy", 64'(busy), 64'd0);
        exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;

        run_op(OP_MULT, 32'hFFFFFFFF, 32'h2);
        check("mult_lit", {32'(hi_o), 32'(lo_o)}, 64'hFFFFFFFF_FFFFFFFE);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'h2);
        check("multu_lit", {32'(hi_o), 32'(lo_o)}, 64'h00000001_FFFFFFFE);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'h2);
        check("div_lit", {32'(hi_o), 32'(lo_o)}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(OP_DIVU, 32'd100, 32'd7);
        check("divu_lit", {32'(hi_o), 32'(lo_o)}, {32'd2, 32'd14});
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lit", {32'(hi_o), 32'(lo_o)}, 64'h00000000_80000000);

        issue_mt(OP_MTHI, 32'h0000AAAA);
        issue_mt(OP_MTLO, 32'h00005555);
        run_op(OP_DIVU, 32'd5, 32'd0);
        check("dz_keep", {32'(hi_o), 32'(lo_o)}, 64'h0000AAAA_00005555);

        // Flush mid-RUN.
        seen = 1'b0;
        @(negedge cpu_clk_50M);
        start = 1'b1; op = OP_MULT; src_a = 32'h1234; src_b = 32'h5678;
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge cpu_clk_50M);
            if (k == 1) start = 1'b0;
            if (k == 10) flush = 1'b1;
            if (k == 11) begin
                flush = 1'b0;
                check("flush_busy", 64'(busy), 64'd0);
            end
            if (done || div_zero) seen = 1'b1;
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_hilo", {32'(hi_o), 32'(lo_o)}, {32'(exp_hi), 32'(exp_lo)});

        // Flush beats an MTLO request in IDLE.
        @(negedge cpu_clk_50M);
        start = 1'b1; op = OP_MTLO; src_a = 32'hDEADBEEF; flush = 1'b1;
        @(negedge cpu_clk_50M);
        start = 1'b0; flush = 1'b0;
        check("flush_mtlo", 64'(lo_o), 64'(exp_lo));

        // Asynchronous reset in the middle of a divide.
        issue_mt(OP_MTHI, 32'h0BADF00D);
        @(negedge cpu_clk_50M);
        start = 1'b1; op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge cpu_clk_50M);
            start = 1'b0;
        end
        cpu_rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi_o), 64'd0);
        check("arst_lo", 64'(lo_o), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        exp_hi = '0; exp_lo = '0;
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        run_op(OP_MULTU, 32'd3, 32'd5);
        check("post_rst_lit", {32'(hi_o), 32'(lo_o)}, {32'd0, 32'd15});

        // Randomized mix against the model.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(0, 9));
                1: b = '0;
                2: b = 32'hFFFFFFFF;
                3: a = 32'h80000000;
                default: ;
            endcase
            case ($urandom_range(0, 9))
                0: issue_mt(OP_MTHI, a);
                1: issue_mt(OP_MTLO, a);
                default: begin
                    o = 3'($urandom_range(1, 4));
                    run_op(o, a, b);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
